// File: rtl/blk_inner_prod_mac.sv
// blk_inner_prod_mac
// Multiplies unsigned sample pairs and accumulates BLK_LEN products into one
// inner product. The result is saturated to OUT_WID bits and presented with a
// single-cycle valid pulse for the downstream rounding stage.
// Pipeline: stage 1 registers the full-precision product and its position in
// the block; stage 2 accumulates and registers the saturated output.
module blk_inner_prod_mac #(
  parameter int DAT_WID = 8,
  parameter int BLK_LEN = 16,
  parameter int OUT_WID = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DAT_WID-1:0] a_i,
  input  logic [DAT_WID-1:0] b_i,
  input  logic               dat_i_en,
  input  logic               flush_i,
  output logic [OUT_WID-1:0] dat_o,
  output logic               dat_o_en,
  output logic               sat_o
);

  localparam int PROD_WID = 2 * DAT_WID;
  // Accumulator is sized so BLK_LEN maximal products can never overflow it.
  localparam int ACC_WID  = PROD_WID + ((BLK_LEN > 1) ? $clog2(BLK_LEN) : 0);
  localparam int CNT_WID  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

  localparam logic [CNT_WID-1:0] CNT_LAST = CNT_WID'(BLK_LEN - 1);
  localparam logic [ACC_WID-1:0] SAT_MAX  = ACC_WID'({OUT_WID{1'b1}});

  logic [CNT_WID-1:0]  cnt;
  logic [PROD_WID-1:0] prod_w;
  logic [PROD_WID-1:0] prod_r;
  logic                prod_vld;
  logic                prod_first;
  logic                prod_last;

  logic [ACC_WID-1:0]  acc;
  logic [ACC_WID-1:0]  sum;
  logic                sat;

  // Operands are widened first so the product keeps full precision.
  assign prod_w = PROD_WID'(a_i) * PROD_WID'(b_i);

  // Stage 1: capture product and tag it with its position inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      prod_r     <= '0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
    end else if (flush_i) begin
      // Flush wins over a simultaneous sample; that sample is dropped.
      cnt      <= '0;
      prod_vld <= 1'b0;
    end else if (dat_i_en) begin
      prod_r     <= prod_w;
      prod_vld   <= 1'b1;
      prod_first <= (cnt == '0);
      prod_last  <= (cnt == CNT_LAST);
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CNT_WID'(1);
    end else begin
      prod_vld <= 1'b0;
    end
  end

  // The first product of a block restarts the sum, so no stale value carries
  // over into back-to-back blocks.
  assign sum = (prod_first ? '0 : acc) + ACC_WID'(prod_r);
  assign sat = (sum > SAT_MAX);

  // Stage 2: accumulate; on the last product issue the saturated result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      dat_o    <= '0;
      dat_o_en <= 1'b0;
      sat_o    <= 1'b0;
    end else begin
      dat_o_en <= 1'b0;
      if (flush_i) begin
        // Any product waiting in stage 1 is discarded, including a last one.
        // dat_o/sat_o keep their previous result.
        acc <= '0;
      end else if (prod_vld) begin
        acc <= sum;
        if (prod_last) begin
          dat_o    <= sat ? '1 : sum[OUT_WID-1:0];
          sat_o    <= sat;
          dat_o_en <= 1'b1;
        end
      end
    end
  end

endmodule
